turn_req_gen: RTL
=================

// Module: turn_req_gen
// PURPOSE
//   Upstream stage of the lamp-sequencing FSM (L/M/R lights).
//   - Synchronises and debounces the raw turn button.
//   - Toggles a turn request on each press.
//   - Generates the slow step strobe that paces the lamp sequence.
//   - On stop, drains to a sequence boundary so the lights never freeze mid-sweep.
// PARAMETERS
//   DEB_CYCLES     1_000_000   cycles btn_sync must differ from btn_db before btn_db flips (>=2)
//   TICK_DIV       25_000_000  clk cycles per step pulse (>=2)
//   TIMEOUT_STEPS  64          steps in ACTIVE before auto-stop (used only with TURN_TIMEOUT_EN)
// PORTS
//   clk      in   1  system clock, all logic on posedge
//   reset    in   1  synchronous, active-high; all state to reset values
//   btn_raw  in   1  asynchronous raw pushbutton, high = pressed
//   enable   out  1  turn request to lamp FSM; 1 only in ACTIVE
//   step     out  1  one-cycle strobe, lamp FSM advances one state per strobe
//   active   out  1  1 whenever state != IDLE
//   phase    out  2  steps taken mod 4; 0 = lamp sequence at rest position
// BEHAVIOUR
//   Reset values
//   - All outputs 0.
//   - Synchroniser FFs, btn_db, debounce counter, prescaler, phase and timeout counter all 0.
//   - State = IDLE.
//   Input path
//   - 2-FF synchroniser: btn_raw -> btn_sync.
//   - Debounce counter increments each cycle btn_sync != btn_db; it clears when they are equal.
//   - When the counter == DEB_CYCLES-1 and the inputs still mismatch: btn_db <= btn_sync, counter <= 0.
//   - press = btn_db & ~btn_db_q, one cycle wide. Release is never a press.
//   - Latency: enable rises after exactly DEB_CYCLES+3 posedges, counting the first edge that samples btn_raw=1.
//   Prescaler
//   - cnt is held at 0 in IDLE. It is cleared on IDLE->ACTIVE.
//   - In ACTIVE/DRAIN it counts 0..TICK_DIV-1 and wraps.
//   - step = (cnt == TICK_DIV-1) & (state != IDLE), combinational.
//   - The first step falls in the TICK_DIV-th cycle after entering ACTIVE.
//   - phase increments mod 4 on every step. It is held in IDLE.
//   State machine (state register updates on posedge)
//   - IDLE   : press -> ACTIVE.
//   - ACTIVE : press & phase==0 -> IDLE.
//              press & phase!=0 -> DRAIN.
//   - DRAIN  : enable=0, steps continue.
//              A step that wraps phase 3->0 -> IDLE (that step is still emitted).
//              press -> ACTIVE; phase and cnt preserved, no restart.
//   Boundary rules
//   - press and step in the same cycle: step is emitted and phase advances first. The transition then uses the updated phase.
//   - Button held through reset: after reset deasserts, btn_db=0 still mismatches. A new press is detected and ACTIVE is entered normally.
//   - Reset mid-DRAIN: immediate IDLE, phase=0, no further steps.
//   - Bounce shorter than DEB_CYCLES consecutive cycles: no press, no state change.
// CONFIGURATION
//   TURN_TIMEOUT_EN defined
//   - A step counter counts steps in ACTIVE. It clears on entry to ACTIVE, including DRAIN->ACTIVE.
//   - When it reaches TIMEOUT_STEPS, the FSM acts as if press occurred: DRAIN, or IDLE if phase==0.
//   - A real press in the same cycle is treated as one press.
//   TURN_TIMEOUT_EN undefined
//   - No counter logic. ACTIVE persists until a press; TIMEOUT_STEPS is ignored.
// TESTING  (DEB_CYCLES=4, TICK_DIV=5, TIMEOUT_STEPS=8)
//   1. Reset 3 cycles, btn_raw=0 -> enable=step=active=0, phase=0 throughout.
//   2. btn_raw 0->1 held -> enable=1 on posedge 7; first step 5 cycles later; phase 1,2,3,0,1.. on successive steps.
//   3. btn_raw toggled 3 cycles high / 3 cycles low, repeated 20 cycles -> no press, state stays IDLE.
//   4. Stop press landing at phase=2 -> enable=0, active=1. Exactly 2 more steps follow; active=0 after the step taking phase to 0.
//   5. Press during DRAIN (phase=3) -> enable=1 immediately. Next step is 5 cycles after the previous step; phase continues at 0.
//   6. TURN_TIMEOUT_EN: hold no press after arming -> 8th step forces DRAIN/IDLE. Without the macro -> still ACTIVE after 20 steps.

Source files
------------

// File: rtl/turn_req_gen.sv
// Turn-request front end: button sync/debounce, request toggle, step prescaler, drain-to-rest FSM.
// Optional step-count auto-stop is built when TURN_TIMEOUT_EN is defined.
module turn_req_gen #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned TICK_DIV      = 25_000_000,
  parameter int unsigned TIMEOUT_STEPS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       enable,
  output logic       step,
  output logic       active,
  output logic [1:0] phase
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t           state;
  logic             sync_1;
  logic             btn_sync;
  logic             btn_db;
  logic             btn_db_q;
  logic [DEB_W-1:0] deb_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       phase_upd;
  logic             press;
  logic             req;
  logic             wrap;

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_STEPS + 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  // Steps spent in ACTIVE; held at zero elsewhere so every entry starts fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != ACTIVE) begin
      to_cnt <= '0;
    end else if (step) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout = (state == ACTIVE) && step && (to_cnt == TO_W'(TIMEOUT_STEPS - 1));
`endif

  // Press edge, step strobe and the phase value the FSM decides on
  always_comb begin
    press     = btn_db & ~btn_db_q;
    step      = (state != IDLE) && (cnt == CNT_W'(TICK_DIV - 1));
    phase_upd = step ? phase + 2'd1 : phase;
    wrap      = step && (phase == 2'd3);
    cnt_nxt   = step ? '0 : cnt + CNT_W'(1);
`ifdef TURN_TIMEOUT_EN
    req       = press | timeout;
`else
    req       = press;
`endif
  end

  // Two-flop synchroniser followed by a run-length debouncer
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1   <= 1'b0;
      btn_sync <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync_1   <= btn_raw;
      btn_sync <= sync_1;
      btn_db_q <= btn_db;
      if (btn_sync != btn_db) begin
        if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          btn_db  <= btn_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Request FSM; in DRAIN a press wins over a simultaneous wrap to rest
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      enable <= 1'b0;
      active <= 1'b0;
      phase  <= 2'd0;
      cnt    <= '0;
    end else begin
      phase <= phase_upd;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press) begin
            state  <= ACTIVE;
            enable <= 1'b1;
            active <= 1'b1;
          end
        end
        ACTIVE: begin
          cnt <= cnt_nxt;
          if (req) begin
            enable <= 1'b0;
            if (phase_upd == 2'd0) begin
              state  <= IDLE;
              active <= 1'b0;
              cnt    <= '0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt <= cnt_nxt;
          if (press) begin
            state  <= ACTIVE;
            enable <= 1'b1;
          end else if (wrap) begin
            state  <= IDLE;
            active <= 1'b0;
            cnt    <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          active <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule
